// File: rtl/fp_trace_writer_pkg.sv
// fp_wire: record layout, opcode bit indices and field positions for the FP trace path
package fp_wire;
  localparam int REC_W = 288;
  localparam int OP_FMADD = 0;
  localparam int OP_FADD = 1;
  localparam int OP_FSUB = 2;
  localparam int OP_FMUL = 3;
  localparam int OP_FDIV = 4;
  localparam int OP_FSQRT = 5;
  localparam int OP_FCMP = 6;
  localparam int OP_FCVT_F2F = 7;
  localparam int OP_FCVT_I2F = 8;
  localparam int OP_FCVT_F2I = 9;
  localparam int REC_DATA1_LSB = 224;
  localparam int REC_DATA2_LSB = 160;
  localparam int REC_DATA3_LSB = 96;
  localparam int REC_RESULT_LSB = 32;
  localparam int REC_FLAGS_LSB = 24;
  localparam int REC_FMT_LSB = 20;
  localparam int REC_RM_LSB = 16;
  localparam int REC_OP_LSB = 12;
  localparam int REC_OPCODE_LSB = 0;
  typedef struct packed {
    logic [63:0] data1;
    logic [63:0] data2;
    logic [63:0] data3;
    logic [63:0] result;
    logic [2:0]  pad0;
    logic [4:0]  flags;
    logic [1:0]  pad1;
    logic [1:0]  fmt;
    logic        pad2;
    logic [2:0]  rm;
    logic [1:0]  pad3;
    logic [1:0]  op;
    logic [1:0]  pad4;
    logic [9:0]  opcode;
  } fp_trace_rec_type;
endpackage

// File: rtl/fp_trace_writer_if.sv
// fp_trace_writer_if: issue/completion snoop, record stream and status signals of the trace writer
//   master: the environment (issuer, fp unit, downstream logger); slave: fp_trace_writer.
interface fp_trace_writer_if #(parameter int LAT_W = 16);
  logic             iss_enable;
  logic [63:0]      iss_data1;
  logic [63:0]      iss_data2;
  logic [63:0]      iss_data3;
  logic [1:0]       iss_fmt;
  logic [2:0]       iss_rm;
  logic [1:0]       iss_op;
  logic [9:0]       iss_opcode;
  logic             cmp_ready;
  logic [63:0]      cmp_result;
  logic [4:0]       cmp_flags;
  logic             iss_stall;
  logic             rec_valid;
  logic             rec_ready;
  logic [287:0]     rec_data;
  logic [LAT_W-1:0] rec_latency;
  logic             overflow;
  logic             proto_err;
  modport master (
    output iss_enable, iss_data1, iss_data2, iss_data3, iss_fmt, iss_rm, iss_op, iss_opcode,
    output cmp_ready, cmp_result, cmp_flags, rec_ready,
    input  iss_stall, rec_valid, rec_data, rec_latency, overflow, proto_err
  );
  modport slave (
    input  iss_enable, iss_data1, iss_data2, iss_data3, iss_fmt, iss_rm, iss_op, iss_opcode,
    input  cmp_ready, cmp_result, cmp_flags, rec_ready,
    output iss_stall, rec_valid, rec_data, rec_latency, overflow, proto_err
  );
endinterface

// File: rtl/fp_trace_fifo.sv
// fp_trace_fifo: synchronous FIFO, W bits wide, DEPTH entries (power of two)
//   clock, reset (async, active-high); push/din, pop/dout, full, empty, count.
//   A push while full is accepted only when a pop happens in the same cycle.
module fp_trace_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clock)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/fp_trace_writer.sv
// fp_trace_writer: pairs fp_exe issues with completions and streams packed fpu.dat records
//   clock, reset (async, active-high); bus (fp_trace_writer_if.slave): issue/completion snoop,
//   rec_valid/rec_ready/rec_data/rec_latency stream, iss_stall, sticky overflow and proto_err.
//   Macro FP_TRACE_LATENCY_EN adds an issue-to-completion latency stored with each record.
module fp_trace_writer
  import fp_wire::*;
#(
  parameter int DEPTH = 8,
  parameter int LAT_W = 16
) (
  input logic              clock,
  input logic              reset,
  fp_trace_writer_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;
  logic [0:0] state;
  fp_trace_rec_type req, cap, rec, head;
  logic capture, complete, pop, full, empty;
  logic [CW-1:0] count;
  assign complete = state == PEND && bus.cmp_ready;
  // a completion frees the slot, so an issue in the same cycle is captured back-to-back
  assign capture = bus.iss_enable && (state == IDLE || bus.cmp_ready);
  assign pop = bus.rec_valid && bus.rec_ready;
  assign bus.rec_valid = !empty;
  assign bus.rec_data = bus.rec_valid ? head : '0;
  assign bus.iss_stall = ({1'b0, count} + {{CW{1'b0}}, state}) >= (CW + 1)'(DEPTH);
  always_comb begin
    cap = '0;
    cap.data1 = bus.iss_data1;
    cap.data2 = bus.iss_data2;
    cap.data3 = bus.iss_data3;
    cap.fmt = bus.iss_fmt;
    cap.rm = bus.iss_rm;
    cap.op = bus.iss_op;
    cap.opcode = bus.iss_opcode;
    rec = req;
    rec.result = bus.cmp_result;
    rec.flags = bus.cmp_flags;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      req <= '0;
      bus.overflow <= 1'b0;
      bus.proto_err <= 1'b0;
    end else begin
      state <= capture ? PEND : complete ? IDLE : state;
      if (capture) req <= cap;
      if (complete && full && !pop) bus.overflow <= 1'b1;
      if ((state == PEND && bus.iss_enable && !bus.cmp_ready) || (state == IDLE && bus.cmp_ready))
        bus.proto_err <= 1'b1;
    end
`ifdef FP_TRACE_LATENCY_EN
  logic [LAT_W-1:0] lat, head_lat;
  logic [REC_W+LAT_W-1:0] din, dout;
  always_ff @(posedge clock or posedge reset)
    if (reset) lat <= '0;
    else if (capture) lat <= LAT_W'(1);
    else if (state == PEND && lat != '1) lat <= lat + 1'b1;
  assign din = {rec, lat};
  assign {head, head_lat} = dout;
  assign bus.rec_latency = bus.rec_valid ? head_lat : '0;
`else
  logic [REC_W-1:0] din, dout;
  assign din = rec;
  assign head = dout;
  assign bus.rec_latency = '0;
`endif
  fp_trace_fifo #(.W($bits(din)), .DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(complete),
    .pop(pop),
    .din(din),
    .dout(dout),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule

// File: tb/tb_fp_trace_writer.sv
// tb_fp_trace_writer: directed table, corner-case sequences and random traffic against a queue model
module tb_fp_trace_writer;
  localparam int DEPTH = 8;
  localparam int LAT_W = 16;
`ifdef FP_TRACE_LATENCY_EN
  localparam bit LAT_EN = 1'b1;
`else
  localparam bit LAT_EN = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  fp_trace_writer_if #(.LAT_W(LAT_W)) bus();
  fp_trace_writer #(.DEPTH(DEPTH), .LAT_W(LAT_W)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int pops = 0;
  typedef struct { logic [287:0] rec; logic [LAT_W-1:0] lat; } ent_t;
  ent_t q[$];
  logic m_pend = 1'b0, m_ovf = 1'b0, m_perr = 1'b0;
  logic [63:0] m_d1, m_d2, m_d3;
  logic [1:0] m_fmt, m_op;
  logic [2:0] m_rm;
  logic [9:0] m_opc;
  int m_cyc = 0, m_iss = 0;
  logic en_r, cmp_r, rdy_r;
  logic [63:0] a_d1;

  typedef struct {
    logic en, cmp, rdy;
    logic [63:0] d1, d2, res;
    logic [1:0] fmt;
    logic [2:0] rm;
    logic [9:0] opc;
    logic [4:0] flags;
    logic exp_valid;
    logic [287:0] exp_rec;
    logic [LAT_W-1:0] exp_lat;
  } vec_t;
  vec_t tbl[8];

  function automatic vec_t mk(logic en, logic cmp, logic rdy, logic [63:0] d1, logic [63:0] d2,
                              logic [63:0] res, logic [1:0] fmt, logic [2:0] rm, logic [9:0] opc,
                              logic [4:0] flags, logic ev, logic [287:0] er, int el);
    vec_t v;
    v.en = en; v.cmp = cmp; v.rdy = rdy; v.d1 = d1; v.d2 = d2; v.res = res;
    v.fmt = fmt; v.rm = rm; v.opc = opc; v.flags = flags;
    v.exp_valid = ev; v.exp_rec = er; v.exp_lat = LAT_EN ? LAT_W'(el) : '0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs();
    chk("rec_valid", bus.rec_valid, q.size() > 0);
    chk("iss_stall", bus.iss_stall, (q.size() + m_pend) >= DEPTH);
    chk("overflow", bus.overflow, m_ovf);
    chk("proto_err", bus.proto_err, m_perr);
    if (q.size() > 0) begin
      chk("rec_data", bus.rec_data, q[0].rec);
      chk("rec_latency", bus.rec_latency, q[0].lat);
    end
  endtask

  // Reference: one outstanding request, a bounded queue of records, sticky error flags.
  task automatic model_edge();
    bit was, pop;
    int d;
    ent_t e;
    m_cyc++;
    was = m_pend;
    pop = q.size() > 0 && bus.rec_ready;
    if (was && bus.cmp_ready) begin
      d = m_cyc - m_iss;
      e.rec = {m_d1, m_d2, m_d3, bus.cmp_result, 3'b0, bus.cmp_flags, 2'b0, m_fmt,
               1'b0, m_rm, 2'b0, m_op, 2'b0, m_opc};
      e.lat = !LAT_EN ? '0 : (d > (2 ** LAT_W - 1)) ? '1 : LAT_W'(d);
      if (q.size() == DEPTH && !pop) m_ovf = 1'b1;
      if (pop) begin void'(q.pop_front()); pops++; end
      if (!(q.size() == DEPTH)) q.push_back(e);
      m_pend = 1'b0;
    end else if (pop) begin
      void'(q.pop_front());
      pops++;
    end
    if (was && bus.iss_enable && !bus.cmp_ready) m_perr = 1'b1;
    if (!was && bus.cmp_ready) m_perr = 1'b1;
    if (bus.iss_enable && !m_pend) begin
      m_d1 = bus.iss_data1; m_d2 = bus.iss_data2; m_d3 = bus.iss_data3;
      m_fmt = bus.iss_fmt; m_rm = bus.iss_rm; m_op = bus.iss_op; m_opc = bus.iss_opcode;
      m_iss = m_cyc;
      m_pend = 1'b1;
    end
  endtask

  task automatic cyc(input logic en, input logic cmp, input logic rdy);
    check_outs();
    bus.iss_enable = en;
    bus.cmp_ready = cmp;
    bus.rec_ready = rdy;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic set_op();
    bus.iss_data1 = {$urandom, $urandom};
    bus.iss_data2 = {$urandom, $urandom};
    bus.iss_data3 = {$urandom, $urandom};
    bus.iss_fmt = 2'($urandom_range(0, 3));
    bus.iss_rm = 3'($urandom_range(0, 7));
    bus.iss_op = 2'($urandom_range(0, 3));
    bus.iss_opcode = 10'(1 << $urandom_range(0, 9));
    bus.cmp_result = {$urandom, $urandom};
    bus.cmp_flags = 5'($urandom_range(0, 31));
  endtask

  // Asynchronous reset between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    q.delete();
    m_pend = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
    check_outs();
    chk("reset_rec_data", bus.rec_data, '0);
    chk("reset_rec_latency", bus.rec_latency, '0);
    bus.iss_enable = 1'b0; bus.cmp_ready = 1'b0; bus.rec_ready = 1'b0;
    #1 reset = 1'b0;
  endtask

  initial begin
    bus.iss_enable = 1'b0; bus.cmp_ready = 1'b0; bus.rec_ready = 1'b0;
    bus.iss_data1 = '0; bus.iss_data2 = '0; bus.iss_data3 = '0;
    bus.iss_fmt = '0; bus.iss_rm = '0; bus.iss_op = '0; bus.iss_opcode = '0;
    bus.cmp_result = '0; bus.cmp_flags = '0;
    repeat (2) @(posedge clock);
    #1;
    check_outs();
    chk("reset_rec_data", bus.rec_data, '0);
    chk("reset_rec_latency", bus.rec_latency, '0);
    reset = 1'b0;

    tbl[0] = mk(1, 0, 0, 64'h3F800000, 64'h40000000, 64'h0, 2'd0, 3'd0, 10'h002, 5'd0, 0, '0, 0);
    tbl[1] = mk(0, 0, 0, 64'h0, 64'h0, 64'h0, 2'd0, 3'd0, 10'h000, 5'd0, 0, '0, 0);
    tbl[2] = mk(0, 0, 0, 64'h0, 64'h0, 64'h0, 2'd0, 3'd0, 10'h000, 5'd0, 0, '0, 0);
    tbl[3] = mk(0, 1, 0, 64'h0, 64'h0, 64'h40400000, 2'd0, 3'd0, 10'h000, 5'd0, 0, '0, 0);
    tbl[4] = mk(1, 0, 1, 64'h3FF0000000000000, 64'h0, 64'h0, 2'd1, 3'd1, 10'h010, 5'd0, 1,
                {64'h3F800000, 64'h40000000, 64'h0, 64'h40400000, 32'h00000002}, 3);
    tbl[5] = mk(0, 1, 0, 64'h0, 64'h0, 64'h7FF0000000000000, 2'd0, 3'd0, 10'h000, 5'b01000, 0, '0, 0);
    tbl[6] = mk(0, 0, 1, 64'h0, 64'h0, 64'h0, 2'd0, 3'd0, 10'h000, 5'd0, 1,
                {64'h3FF0000000000000, 64'h0, 64'h0, 64'h7FF0000000000000, 32'h08110010}, 1);
    tbl[7] = mk(0, 0, 0, 64'h0, 64'h0, 64'h0, 2'd0, 3'd0, 10'h000, 5'd0, 0, '0, 0);
    foreach (tbl[i]) begin
      chk($sformatf("tbl%0d_valid", i), bus.rec_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_rec", i), bus.rec_data, tbl[i].exp_rec);
        chk($sformatf("tbl%0d_lat", i), bus.rec_latency, tbl[i].exp_lat);
      end
      bus.iss_data1 = tbl[i].d1; bus.iss_data2 = tbl[i].d2; bus.iss_data3 = '0;
      bus.iss_fmt = tbl[i].fmt; bus.iss_rm = tbl[i].rm; bus.iss_op = '0;
      bus.iss_opcode = tbl[i].opc; bus.cmp_result = tbl[i].res; bus.cmp_flags = tbl[i].flags;
      cyc(tbl[i].en, tbl[i].cmp, tbl[i].rdy);
    end

    // back-to-back: five operations, each completion overlapping the next issue
    pops = 0;
    set_op(); cyc(1, 0, 1);
    repeat (4) begin set_op(); cyc(1, 1, 1); end
    set_op(); cyc(0, 1, 1);
    repeat (3) cyc(0, 0, 1);
    chk("b2b_records", 288'(pops), 288'(5));
    chk("b2b_proto_err", bus.proto_err, 1'b0);

    // back-pressure: fill to DEPTH, force one more, then drain
    set_op(); cyc(1, 0, 0);
    repeat (7) begin set_op(); cyc(1, 1, 0); end
    chk("stall_at_depth", bus.iss_stall, 1'b1);
    set_op(); cyc(0, 1, 0);
    chk("stall_full", bus.iss_stall, 1'b1);
    chk("no_overflow_yet", bus.overflow, 1'b0);
    set_op(); cyc(1, 0, 0);
    set_op(); cyc(0, 1, 0);
    chk("overflow_set", bus.overflow, 1'b1);
    pops = 0;
    repeat (10) cyc(0, 0, 1);
    chk("drain_count", 288'(pops), 288'(8));

    // protocol errors keep the first request intact
    do_reset();
    set_op(); cyc(0, 1, 0);
    chk("proto_idle_cmp", bus.proto_err, 1'b1);
    chk("proto_no_rec", bus.rec_valid, 1'b0);
    set_op(); a_d1 = bus.iss_data1; cyc(1, 0, 0);
    set_op(); cyc(1, 0, 0);
    set_op(); cyc(0, 1, 0);
    chk("proto_first_kept", 288'(bus.rec_data[287:224]), 288'(a_d1));
    pops = 0;
    repeat (3) cyc(0, 0, 1);
    chk("proto_one_rec", 288'(pops), 288'(1));

    // async reset with 3 queued records and one pending request
    do_reset();
    repeat (3) begin set_op(); cyc(1, 0, 0); set_op(); cyc(0, 1, 0); end
    set_op(); cyc(1, 0, 0);
    do_reset();
    chk("rst_valid", bus.rec_valid, 1'b0);
    chk("rst_stall", bus.iss_stall, 1'b0);
    set_op(); cyc(1, 0, 0);
    cyc(0, 0, 0);
    set_op(); cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);

    // random traffic, mostly stall-compliant, with one mid-run reset
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      en_r = ($urandom_range(0, 2) == 0) && (((q.size() + m_pend) < DEPTH) || ($urandom_range(0, 29) == 0));
      cmp_r = $urandom_range(0, 2) == 0 && (m_pend || $urandom_range(0, 39) == 0);
      rdy_r = $urandom_range(0, 1) == 1;
      set_op();
      cyc(en_r, cmp_r, rdy_r);
    end
    check_outs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
